// File: rtl/relu_single.sv
// relu_single: element-wise ReLU over one flattened W x H feature map.
// Each signed element is either passed through unchanged or forced to zero
// when its sign bit is set. The whole map is registered with one cycle of
// latency, and a per-element mask reports which elements were clamped.
module relu_single #(
  parameter int W          = 5,
  parameter int H          = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [W*H*DATA_WIDTH-1:0] in,
  output logic                      out_valid,
  output logic [W*H*DATA_WIDTH-1:0] out,
  output logic [W*H-1:0]            clamp_mask
);

  localparam int N = W * H;

  logic [N*DATA_WIDTH-1:0] relu_map;
  logic [N-1:0]            relu_mask;

  // Sign test and select for every element in parallel; no arithmetic, so
  // there is no width growth, rounding or saturation.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    relu_map  = '0;
    relu_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
        relu_map[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        relu_mask[i]                         = 1'b1;
      end else begin
        relu_map[i*DATA_WIDTH +: DATA_WIDTH] = in[i*DATA_WIDTH +: DATA_WIDTH];
        relu_mask[i]                         = 1'b0;
      end
    end
  end

  // Output register: synchronous reset wins over any input; data and mask
  // only load on a valid map and otherwise hold, while valid tracks in_valid.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out        <= '0;
      clamp_mask <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out        <= relu_map;
        clamp_mask <= relu_mask;
      end
    end
  end

endmodule

// File: tb/tb_relu_single.sv
// Self-checking bench for relu_single: directed cases from the behaviour
// description, a randomized stream against a value-level reference model,
// and a second instance with a small, narrow configuration.
module tb_relu_single;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = 16;
  localparam int N  = W * H;
  localparam int VW = 400;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [N*DW-1:0]   in_m;
  logic              out_valid;
  logic [N*DW-1:0]   out_m;
  logic [N-1:0]      mask_m;

  // Small configuration: 3 x 2 map of 8-bit elements.
  logic              in_valid_s;
  logic [47:0]       in_s;
  logic              out_valid_s;
  logic [47:0]       out_s;
  logic [5:0]        mask_s;

  int checks = 0;
  int errors = 0;

  // Expected state held by the reference model for the main instance.
  logic [VW-1:0] exp_out;
  logic [VW-1:0] exp_mask;
  logic          exp_valid;

  relu_single #(.W(W), .H(H), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in         (in_m),
    .out_valid  (out_valid),
    .out        (out_m),
    .clamp_mask (mask_m)
  );

  relu_single #(.W(3), .H(2), .DATA_WIDTH(8)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_s),
    .in         (in_s),
    .out_valid  (out_valid_s),
    .out        (out_s),
    .clamp_mask (mask_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] observed,
                       input logic [VW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: interpret each element as a signed integer; negative values
  // become 0 and set the mask bit, everything else is copied.
  task automatic relu_model(input int n, input int dw, input logic [VW-1:0] v,
                            output logic [VW-1:0] o, output logic [VW-1:0] m);
    longint elem;
    longint value;
    o = '0;
    m = '0;
    for (int i = 0; i < n; i++) begin
      elem = 0;
      for (int b = 0; b < dw; b++) if (v[i*dw + b]) elem += (longint'(1) << b);
      value = (elem >= (longint'(1) << (dw - 1))) ? elem - (longint'(1) << dw) : elem;
      if (value < 0) begin
        m[i] = 1'b1;
      end else begin
        for (int b = 0; b < dw; b++) o[i*dw + b] = elem[b];
      end
    end
  endtask

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] val);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = val;
    return r;
  endfunction

  function automatic logic [N*DW-1:0] rand_map();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Advance one edge on the model and the DUT, then sample 1 time unit later.
  task automatic step();
    logic [VW-1:0] o;
    logic [VW-1:0] m;
    if (!rst_n) begin
      exp_out   = '0;
      exp_mask  = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        relu_model(N, DW, VW'(in_m), o, m);
        exp_out  = o;
        exp_mask = m;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},       VW'(out_m),     exp_out);
    check({tag, ".mask"},      VW'(mask_m),    exp_mask);
    check({tag, ".out_valid"}, VW'(out_valid), VW'(exp_valid));
  endtask

  initial begin
    logic [N*DW-1:0] bmap;
    exp_out    = '0;
    exp_mask   = '0;
    exp_valid  = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_m       = rand_map();
    in_valid_s = 1'b1;
    in_s       = 48'h80_FF_80_FF_80_FF;
    #2;

    // Reset held two cycles with valid inputs present: everything zero.
    for (int c = 0; c < 2; c++) begin
      step();
      check("reset.out",       VW'(out_m),       '0);
      check("reset.mask",      VW'(mask_m),      '0);
      check("reset.out_valid", VW'(out_valid),   '0);
      check("reset.small",     VW'({out_valid_s, mask_s, out_s}), '0);
      in_m = rand_map();
    end

    // Alternating pattern: even 0xFFFF, odd 0x0FFF.
    rst_n      = 1'b1;
    in_valid_s = 1'b0;
    for (int i = 0; i < N; i++) in_m[i*DW +: DW] = (i % 2 == 0) ? 16'hFFFF : 16'h0FFF;
    step();
    check_all("alt");
    check("alt.mask_const", VW'(mask_m), VW'(25'h1555555));
    check("alt.elem0", VW'(out_m[15:0]),  VW'(16'h0000));
    check("alt.elem1", VW'(out_m[31:16]), VW'(16'h0FFF));
    in_valid = 1'b0;
    in_m     = rand_map();
    step();
    check_all("alt_hold");

    // Boundary values in elements 0..4, random elsewhere.
    bmap = rand_map();
    bmap[79:0] = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000};
    in_m     = bmap;
    in_valid = 1'b1;
    step();
    check_all("bound");
    check("bound.elems", VW'(out_m[79:0]), VW'({16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 16'h0000}));
    check("bound.mask",  VW'(mask_m[4:0]), VW'(5'b11000));

    // Streaming three maps back to back, then a hold.
    in_m = fill(16'h1234);
    step();
    check_all("stream0");
    check("stream0.const", VW'({mask_m, out_m}), VW'({25'h0, fill(16'h1234)}));
    in_m = fill(16'hF000);
    step();
    check_all("stream1");
    check("stream1.const", VW'({mask_m, out_m}), VW'({25'h1FFFFFF, fill(16'h0000)}));
    in_m = fill(16'h0000);
    step();
    check_all("stream2");
    in_valid = 1'b0;
    in_m     = fill(16'h8000);
    step();
    check_all("stream_hold");

    // Mid-stream reset, then the first map after release.
    in_valid = 1'b1;
    in_m     = rand_map();
    step();
    check_all("mid_pre");
    rst_n = 1'b0;
    in_m  = rand_map();
    step();
    check_all("mid_rst");
    check("mid_rst.zero", VW'({out_valid, mask_m, out_m}), '0);
    rst_n = 1'b1;
    in_m  = rand_map();
    step();
    check_all("mid_post");

    // Small configuration: W=3, H=2, 8-bit elements.
    in_valid   = 1'b0;
    in_valid_s = 1'b1;
    in_s       = {8'hFF, 8'h01, 8'hC3, 8'h00, 8'h7F, 8'h80};
    step();
    check("small.out",   VW'(out_s),       VW'({8'h00, 8'h01, 8'h00, 8'h00, 8'h7F, 8'h00}));
    check("small.mask",  VW'(mask_s),      VW'(6'b101001));
    check("small.valid", VW'(out_valid_s), VW'(1'b1));
    in_valid_s = 1'b0;

    // Randomized stream with random valid and occasional reset.
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      rst_n    = 1'($urandom_range(0, 19) != 0);
      in_m     = rand_map();
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 2) == 0) in_m[i*DW +: DW] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
      step();
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
